mem_analog_delay: RTL and testbench
===================================

Name: mem_analog_delay

Overview:
- Parametrised successor to the single-sample analog memory: a clock-enabled, fixed-point analog delay line of up to DEPTH samples.
- Output delay is selectable at run time (1..DEPTH), with a validity flag and a synchronous flush.
- Used for transport delays, FIR-style history and multi-step state in msdsl-generated models.
- With delay=1 it reproduces plain analog memory behaviour: out follows in one cke edge later.

Parameters:
- init, 0.0, real value driven on out after reset/flush and while not valid (converted to out format).
- DEPTH, 8, maximum delay in cke samples, >=2.
- DW, $clog2(DEPTH+1), width of delay select (localparam).
- in real format (width, exponent) via standard real-format parameter declaration.
- out real format (width, exponent) via standard real-format parameter declaration.

Ports:
- clk  input  1  model clock.
- rst  input  1  asynchronous reset, active-low.
- cke  input  1  sample enable; state advances only when high.
- flush  input  1  synchronous clear of history, priority over cke.
- delay  input  DW  requested delay in samples.
- in  input  in format  analog sample.
- out  output  out format  delayed sample, registered.
- out_valid  output  1  out holds real history (not init).

Behaviour:
- Input alignment: in is converted to out format (shift by exponent difference) before storage; the memory and out register are both in out format.
- Delay clamping: delay_eff = 1 if delay==0; DEPTH if delay>DEPTH; otherwise delay. Sampled every edge; a change takes effect on the next cke edge with no flush.
- Storage: circular buffer mem[0..DEPTH-1], write pointer wptr, fill counter cnt (saturates at DEPTH).
- Reset (rst low, asynchronous): wptr=0, cnt=0, out=init_aligned, out_valid=0. Memory contents are not reset; they are masked by cnt.
- flush=1 at a clk edge: same effect as reset, synchronously, regardless of cke. in is not written on that edge.
- cke=1, flush=0 at edge k:
  - mem[wptr] <= in_aligned; wptr <= wptr+1, wrapping DEPTH-1 -> 0.
  - cnt <= min(cnt+1, DEPTH).
  - out <= in_aligned sampled at cke-edge k-(delay_eff-1). delay_eff=1 bypasses memory (out <= in_aligned).
  - out_valid <= (cnt+1 >= delay_eff). When this is false, out <= init_aligned.
- cke=0, flush=0: all state holds, including out and out_valid.
- Read index = (wptr - (delay_eff-1)) mod DEPTH, using wrap-around arithmetic. It must be correct at every wptr position.
- Latency: one clk from a cke edge to out update. Effective sample delay = delay_eff cke edges (input sampled at edge k appears after edge k+delay_eff-1).
- Reducing delay below cnt: valid immediately; out returns the newer sample.
- Increasing delay beyond cnt: out_valid drops to 0 and out=init until enough samples accumulate.

Optional Feature:
- Macro MEM_ANALOG_DELAY_SAT_EN.
- Defined: alignment of in to out format saturates to the most positive/negative out code on overflow.
- Undefined: the aligned value is truncated to out width (two's-complement wrap), matching existing real-assign behaviour. No saturation logic is synthesised.

Decomposition:
- Package mem_analog_pkg:
  - delay_clamp function (delay, DEPTH -> delay_eff).
  - ptr width helper.
  - circular index function (wptr, offset, DEPTH).
- One sub-module, mem_analog_align: combinational in-format -> out-format conversion, including the SAT_EN path. Also reused for init_aligned.

Test Plan (DEPTH=8; in and out both 16-bit, exponent -12, unless noted):
- Reset/hold: assert rst low mid-run with cke=1 -> out=init immediately (asynchronous), out_valid=0; release, cke=0 for 5 clk -> out unchanged.
- Fixed delay: delay=3, ramp in=1,2,3,... per cke edge -> out_valid rises after 3rd edge with out=1; thereafter out = in - 2 each edge.
- Wrap and clamp: delay=8, drive 20 samples -> out = sample n-7, correct across wptr wrap; delay=0 -> behaves as 1; delay=15 -> behaves as 8.
- Delay change and flush:
  - After 10 samples at delay=2, set delay=6 -> out valid with sample n-5 at the next edge.
  - Set delay=8 after only 4 samples -> out_valid=0, out=init.
  - flush with cke=1 -> cnt cleared, out=init, in not stored.
- cke gating: cke toggles 1,0,0,1 with delay=2 -> only enabled edges count; out tracks the enabled-sample sequence exactly.
- Format/saturation: out exponent -8 width 8, in=+100.0:
  - With MEM_ANALOG_DELAY_SAT_EN -> out = max code (127).
  - Without -> truncated wrap value.
  - in=0.5 -> out code 128 truncated (wrap) vs 127 (saturated).

Source files
------------

// File: rtl/mem_analog_pkg.sv
// mem_analog_pkg: shared helpers for the mem_analog_delay delay line.
// Holds the delay clamping rule, the pointer width and the circular
// read-index arithmetic, so the top and any users agree on them.
package mem_analog_pkg;

   // Smallest pointer width able to address depth entries (at least 1 bit).
   function automatic int ptr_width(input int depth);
      if (depth > 32'sd1) begin
         return $clog2(depth);
      end else begin
         return 32'sd1;
      end
   endfunction

   // Effective delay: 0 behaves as 1, anything above depth behaves as depth.
   function automatic int delay_clamp(input int delay, input int depth);
      if (delay == 32'sd0) begin
         return 32'sd1;
      end else if (delay > depth) begin
         return depth;
      end else begin
         return delay;
      end
   endfunction

   // (wptr - offset) mod depth for 0 <= wptr < depth and 0 <= offset < depth.
   // This works for any depth, including depths that are not a power of two.
   function automatic int circ_index(input int wptr, input int offset, input int depth);
      if (wptr >= offset) begin
         return wptr - offset;
      end else begin
         return wptr + depth - offset;
      end
   endfunction

endpackage

// File: rtl/mem_analog_align.sv
// mem_analog_align: combinational conversion of a fixed-point value from the
// "in" format (in_width, in_exponent) to the "out" format.
// Optional macro MEM_ANALOG_DELAY_SAT_EN: if it is defined, values that do
// not fit are clipped to the most positive/negative out code. If it is not
// defined, the result is truncated to out_width (two's-complement wrap).
module mem_analog_align #(
   parameter int in_width     = 16,
   parameter int in_exponent  = -12,
   parameter int out_width    = 16,
   parameter int out_exponent = -12
) (
   input  logic signed [in_width-1:0]  in,
   output logic signed [out_width-1:0] out
);
   // Positive shift: the out LSB is finer, so shift left. Negative: shift right.
   localparam int SHIFT = in_exponent - out_exponent;
   localparam int LSH   = (SHIFT > 32'sd0) ? SHIFT : 32'sd0;
   localparam int RSH   = (SHIFT < 32'sd0) ? -SHIFT : 32'sd0;
   localparam int WW    = (((in_width + LSH) > out_width) ? (in_width + LSH) : out_width) + 32'sd1;

   logic signed [WW-1:0] ext_s;

   // Sign-extend the input so the shifts do not lose any bits.
   always_comb begin
      ext_s = {{(WW - in_width){in[in_width-1]}}, in};
   end

`ifdef MEM_ANALOG_DELAY_SAT_EN
   localparam logic signed [WW-1:0] SAT_MAX = {{(WW - out_width + 1){1'b0}}, {(out_width - 1){1'b1}}};
   localparam logic signed [WW-1:0] SAT_MIN = {{(WW - out_width + 1){1'b1}}, {(out_width - 1){1'b0}}};

   logic signed [WW-1:0] shifted_s;

   // Align the binary point, then clip to the range of the out format.
   always_comb begin
      shifted_s = (ext_s <<< LSH) >>> RSH;
      if (shifted_s > SAT_MAX) begin
         out = SAT_MAX[out_width-1:0];
      end else if (shifted_s < SAT_MIN) begin
         out = SAT_MIN[out_width-1:0];
      end else begin
         out = shifted_s[out_width-1:0];
      end
   end
`else
   // Align the binary point and keep the low out_width bits (wraps on overflow).
   always_comb begin
      out = out_width'((ext_s <<< LSH) >>> RSH);
   end
`endif

endmodule

// File: rtl/mem_analog_delay.sv
// mem_analog_delay: clock-enabled fixed-point analog delay line of up to DEPTH
// samples. The delay is selected at run time, there is a validity flag, and
// flush clears the history synchronously. With delay=1 it acts as plain analog memory.
// Optional macro MEM_ANALOG_DELAY_SAT_EN selects saturating format alignment
// in mem_analog_align. If the macro is undefined, alignment truncates.
module mem_analog_delay
   import mem_analog_pkg::*;
#(
   parameter real init         = 0.0,
   parameter int  DEPTH        = 8,
   parameter int  in_width     = 16,
   parameter int  in_exponent  = -12,
   parameter int  out_width    = 16,
   parameter int  out_exponent = -12,
   localparam int DW           = $clog2(DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cke,
   input  logic                        flush,
   input  logic [DW-1:0]               delay,
   input  logic signed [in_width-1:0]  in,
   output logic signed [out_width-1:0] out,
   output logic                        out_valid
);
   localparam int PW = ptr_width(DEPTH);
   // init is first quantised to the in format, then aligned like any sample.
   localparam int INIT_IN_CODE = $rtoi(init * (2.0 ** (-in_exponent)));
   localparam logic signed [in_width-1:0] INIT_IN = in_width'(INIT_IN_CODE);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 32'sd1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(32'sd1);
   localparam logic [DW-1:0] CNT_FULL = DW'(DEPTH);
   localparam logic [DW-1:0] CNT_ONE  = DW'(32'sd1);

   logic signed [out_width-1:0] mem_r [DEPTH];
   logic [PW-1:0]               wptr_r, wptr_nx_s, rd_idx_s;
   logic [DW-1:0]               cnt_r, cnt_nx_s, delay_eff_s;
   logic                        valid_r, valid_nx_s, fill_ok_s, mem_we_s;
   logic signed [out_width-1:0] in_aligned_s, init_aligned_s, hist_s;
   logic signed [out_width-1:0] out_r, out_nx_s;

   mem_analog_align #(
      .in_width     (in_width),
      .in_exponent  (in_exponent),
      .out_width    (out_width),
      .out_exponent (out_exponent)
   ) u_in_align (
      .in  (in),
      .out (in_aligned_s)
   );

   mem_analog_align #(
      .in_width     (in_width),
      .in_exponent  (in_exponent),
      .out_width    (out_width),
      .out_exponent (out_exponent)
   ) u_init_align (
      .in  (INIT_IN),
      .out (init_aligned_s)
   );

   // Clamp the requested delay, find the history tap and check the fill level.
   always_comb begin
      delay_eff_s = DW'(delay_clamp(int'(delay), DEPTH));
      rd_idx_s    = PW'(circ_index(int'(wptr_r), int'(delay_eff_s) - 32'sd1, DEPTH));
      fill_ok_s   = (int'(cnt_r) + 32'sd1) >= int'(delay_eff_s);
      hist_s      = (delay_eff_s == CNT_ONE) ? in_aligned_s : mem_r[rd_idx_s];
   end

   // Next state: flush has priority. Otherwise cke advances the line, else hold.
   always_comb begin
      wptr_nx_s  = wptr_r;
      cnt_nx_s   = cnt_r;
      out_nx_s   = out_r;
      valid_nx_s = valid_r;
      mem_we_s   = 1'b0;
      if (flush) begin
         wptr_nx_s  = '0;
         cnt_nx_s   = '0;
         out_nx_s   = init_aligned_s;
         valid_nx_s = 1'b0;
      end else if (cke) begin
         mem_we_s  = 1'b1;
         wptr_nx_s = (wptr_r == PTR_LAST) ? '0 : (wptr_r + PTR_ONE);
         cnt_nx_s  = (cnt_r == CNT_FULL) ? cnt_r : (cnt_r + CNT_ONE);
         if (fill_ok_s) begin
            out_nx_s   = hist_s;
            valid_nx_s = 1'b1;
         end else begin
            out_nx_s   = init_aligned_s;
            valid_nx_s = 1'b0;
         end
      end else begin
         wptr_nx_s  = wptr_r;
         cnt_nx_s   = cnt_r;
         out_nx_s   = out_r;
         valid_nx_s = valid_r;
      end
   end

   // Control state and output register. The asynchronous reset restores init.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_r  <= '0;
         cnt_r   <= '0;
         out_r   <= init_aligned_s;
         valid_r <= 1'b0;
      end else begin
         wptr_r  <= wptr_nx_s;
         cnt_r   <= cnt_nx_s;
         out_r   <= out_nx_s;
         valid_r <= valid_nx_s;
      end
   end

   // Sample storage is not reset. Entries the line has not written are hidden by cnt.
   always_ff @(posedge clk) begin
      if (mem_we_s) begin
         mem_r[wptr_r] <= in_aligned_s;
      end
   end

   assign out       = out_r;
   assign out_valid = valid_r;

endmodule

// File: tb/tb_mem_analog_delay.sv
// tb_mem_analog_delay: checks mem_analog_delay two ways. A history-queue
// reference model tracks every step. Hand-written tables and sequences
// cover the format/saturation cases and the delay-change corner cases.
module tb_mem_analog_delay;
   localparam int DEPTH = 8;
   localparam int DW    = $clog2(DEPTH + 1);
   localparam logic signed [15:0] INIT_CODE = 16'sd2048;   // 0.5 at exponent -12

   typedef struct {
      logic signed [23:0] x;
      logic signed [7:0]  e_sat;
      logic signed [7:0]  e_trunc;
   } fmt_vec_t;

   logic clk = 1'b0;
   logic rst, cke, flush;
   logic [DW-1:0] delay;
   logic signed [15:0] in_a, out_a;
   logic valid_a;
   logic signed [23:0] in_b;
   logic signed [7:0]  out_b;
   logic valid_b;

   int errors = 0;
   int checks = 0;
   logic signed [15:0] hist[$];
   logic signed [15:0] exp_out;
   logic               exp_valid;
   logic signed [15:0] samp [32];
   fmt_vec_t fv [6];

   always #5 clk = ~clk;

   mem_analog_delay #(
      .init(0.5), .DEPTH(DEPTH),
      .in_width(16), .in_exponent(-12), .out_width(16), .out_exponent(-12)
   ) dut (
      .clk(clk), .rst(rst), .cke(cke), .flush(flush), .delay(delay),
      .in(in_a), .out(out_a), .out_valid(valid_a)
   );

   mem_analog_delay #(
      .init(0.0), .DEPTH(DEPTH),
      .in_width(24), .in_exponent(-12), .out_width(8), .out_exponent(-8)
   ) dut_fmt (
      .clk(clk), .rst(rst), .cke(cke), .flush(flush), .delay(delay),
      .in(in_b), .out(out_b), .out_valid(valid_b)
   );

   task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int eff(input int d);
      if (d == 0) return 1;
      else if (d > DEPTH) return DEPTH;
      else return d;
   endfunction

   // One clock: drive the inputs, update the reference model, then check dut.
   task automatic step(input logic c, input logic f, input int d,
                       input logic signed [15:0] x, input logic signed [23:0] x2);
      int de;
      cke = c; flush = f; delay = DW'(d); in_a = x; in_b = x2;
      @(posedge clk);
      de = eff(d);
      if (f) begin
         hist.delete();
         exp_out = INIT_CODE;
         exp_valid = 1'b0;
      end else if (c) begin
         hist.push_back(x);
         if (hist.size() > DEPTH) void'(hist.pop_front());
         if (hist.size() >= de) begin
            exp_out = hist[hist.size() - de];
            exp_valid = 1'b1;
         end else begin
            exp_out = INIT_CODE;
            exp_valid = 1'b0;
         end
      end
      #1;
      check("model_out", out_a, exp_out);
      check("model_valid", valid_a, exp_valid);
   endtask

   initial begin
      fv[0] = '{x: 24'sd409600,  e_sat: 8'sd127,  e_trunc: 8'sd0};    // +100.0
      fv[1] = '{x: 24'sd2048,    e_sat: 8'sd127,  e_trunc: -8'sd128}; // 0.5
      fv[2] = '{x: -24'sd409600, e_sat: -8'sd128, e_trunc: 8'sd0};    // -100.0
      fv[3] = '{x: 24'sd5120,    e_sat: 8'sd127,  e_trunc: 8'sd64};   // 1.25
      fv[4] = '{x: 24'sd1024,    e_sat: 8'sd64,   e_trunc: 8'sd64};   // 0.25
      fv[5] = '{x: -24'sd1232,   e_sat: -8'sd77,  e_trunc: -8'sd77};  // ~-0.3

      rst = 1'b0; cke = 1'b0; flush = 1'b0; delay = DW'(1); in_a = 16'sd0; in_b = 24'sd0;
      exp_out = INIT_CODE; exp_valid = 1'b0;
      #12;
      check("reset_out", out_a, INIT_CODE);
      check("reset_valid", valid_a, 1'b0);
      check("reset_out_fmt", out_b, 8'sd0);
      rst = 1'b1;

      // Fixed delay 3 with a ramp.
      step(1'b1, 1'b1, 3, 16'sd0, 24'sd0);
      for (int i = 1; i <= 12; i++) begin
         step(1'b1, 1'b0, 3, 16'(i), 24'sd0);
         if (i >= 3) begin
            check("ramp_out", out_a, 16'(i - 2));
            check("ramp_valid", valid_a, 1'b1);
         end else begin
            check("ramp_fill_out", out_a, INIT_CODE);
            check("ramp_fill_valid", valid_a, 1'b0);
         end
      end

      // Delay 8 across pointer wrap, then clamp of 0 and 15.
      step(1'b1, 1'b1, 8, 16'sd0, 24'sd0);
      for (int n = 0; n < 20; n++) begin
         samp[n] = 16'($urandom);
         step(1'b1, 1'b0, 8, samp[n], 24'sd0);
         if (n >= 7) check("wrap_out", out_a, samp[n - 7]);
      end
      for (int n = 0; n < 4; n++) begin
         samp[0] = 16'($urandom);
         step(1'b1, 1'b0, 0, samp[0], 24'sd0);
         check("clamp0_out", out_a, samp[0]);
      end
      for (int n = 0; n < 10; n++) step(1'b1, 1'b0, 15, 16'($urandom), 24'sd0);

      // Increase delay after 10 samples at delay 2.
      step(1'b1, 1'b1, 2, 16'sd0, 24'sd0);
      for (int n = 0; n < 10; n++) begin
         samp[n] = 16'(100 + n);
         step(1'b1, 1'b0, 2, samp[n], 24'sd0);
      end
      step(1'b1, 1'b0, 6, 16'sd110, 24'sd0);
      check("grow_out", out_a, samp[5]);
      check("grow_valid", valid_a, 1'b1);

      // Delay 8 after only 4 samples.
      step(1'b1, 1'b1, 2, 16'sd0, 24'sd0);
      for (int n = 0; n < 4; n++) step(1'b1, 1'b0, 2, 16'(200 + n), 24'sd0);
      step(1'b1, 1'b0, 8, 16'sd204, 24'sd0);
      check("short_valid", valid_a, 1'b0);
      check("short_out", out_a, INIT_CODE);

      // A flush with cke=1 must not store its sample.
      step(1'b1, 1'b1, 2, 16'sd999, 24'sd0);
      check("flush_out", out_a, INIT_CODE);
      step(1'b1, 1'b0, 2, 16'sd5, 24'sd0);
      check("flush_nostore_valid", valid_a, 1'b0);
      step(1'b1, 1'b0, 2, 16'sd6, 24'sd0);
      check("flush_after_out", out_a, 16'sd5);

      // cke gating 1,0,0,1 with delay 2.
      step(1'b1, 1'b1, 2, 16'sd0, 24'sd0);
      for (int n = 0; n < 16; n++) step((n % 4 == 0) || (n % 4 == 3), 1'b0, 2, 16'(300 + n), 24'sd0);

      // Format conversion through the second instance with delay 1.
      for (int k = 0; k < 6; k++) begin
         step(1'b1, 1'b0, 1, 16'(k), fv[k].x);
`ifdef MEM_ANALOG_DELAY_SAT_EN
         check("fmt_sat", out_b, fv[k].e_sat);
`else
         check("fmt_trunc", out_b, fv[k].e_trunc);
`endif
         check("fmt_valid", valid_b, 1'b1);
      end

      // Random stimulus against the reference model.
      for (int n = 0; n < 600; n++) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0,
              int'($urandom_range(0, 15)), 16'($urandom), 24'($urandom));
      end

      // Asynchronous reset in mid-run with cke high, then hold with cke low.
      cke = 1'b1; flush = 1'b0; delay = DW'(1); in_a = 16'sd55;
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("async_rst_out", out_a, INIT_CODE);
      check("async_rst_valid", valid_a, 1'b0);
      @(posedge clk);
      #1;
      check("rst_held_out", out_a, INIT_CODE);
      #2;
      rst = 1'b1;
      hist.delete();
      exp_out = INIT_CODE;
      exp_valid = 1'b0;
      for (int n = 0; n < 5; n++) step(1'b0, 1'b0, 1, 16'($urandom), 24'sd0);
      step(1'b1, 1'b0, 1, 16'sd77, 24'sd0);
      check("post_rst_out", out_a, 16'sd77);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
